// File: rtl/jpeg_pkg.sv
// Definitions shared by the JPEG front-end stream blocks: mode codes,
// burst FSM state encoding and the default burst length (one 8x8 block).
package jpeg_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int BLOCK_SAMPLES = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/burst_counter.sv
// Counts accepted samples within a burst. 'last' flags that the next
// accepted sample closes the burst; 'wrap' marks the accept that does so.
module burst_counter
  import jpeg_pkg::*;
#(
  parameter int BURST_LEN = BLOCK_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic last,
  output logic wrap
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] count_reg;

  // Step on every accept; return to zero after the final sample of a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (adv) begin
      count_reg <= last ? '0 : count_reg + 1'b1;
    end
  end

  assign last = (count_reg == LAST_CNT);
  assign wrap = adv && last;

endmodule

// File: rtl/stream_mux_nch.sv
// Registered N-channel stream multiplexer. Bursts of BURST_LEN samples are
// taken from one channel at a time, chosen either by 'sel' or by a strict
// round-robin pointer. The channel is locked for the whole burst.
module stream_mux_nch
  import jpeg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_CH      = 3,
  parameter int BURST_LEN = BLOCK_SAMPLES,
  localparam int SEL_W    = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  state_t              state_reg, state_next;
  logic                run_reg;
  logic [SEL_W-1:0]    lock_ch_reg;
  logic                lock_mode_reg;
  logic [SEL_W-1:0]    rr_ptr_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [SEL_W-1:0]    out_ch_reg;
  logic                out_valid_reg;
  logic                out_last_reg;

  logic [SEL_W-1:0]    cur;
  logic                eff_mode;
  logic                cur_ok;
  logic                can_load;
  logic                accept;
  logic                last;
  logic                wrap;
  logic [DATA_W-1:0]   ch_data [N_CH];

  // Handshakes stay closed until the first clock after reset release, so
  // in_ready is low for the whole time rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Active channel: chosen live while idle, frozen (with its mode) in a burst.
  always_comb begin
    cur      = lock_ch_reg;
    eff_mode = lock_mode_reg;
    if (state_reg == ST_IDLE) begin
      cur      = (mode == MODE_MANUAL) ? sel : rr_ptr_reg;
      eff_mode = mode;
    end
  end

  assign cur_ok   = int'(cur) < N_CH;
  assign can_load = !out_valid_reg || out_ready;
  assign accept   = |(in_valid & in_ready);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = run_reg && can_load && cur_ok && (cur == SEL_W'(gi));
    end
  endgenerate

  burst_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_burst_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (accept),
    .last  (last),
    .wrap  (wrap)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: a burst opens on its first accept unless it is also the
  // last one (single-sample bursts never leave IDLE).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept && !last) state_next = ST_BURST;
      ST_BURST: if (wrap)            state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Capture channel and mode at the start of each burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_ch_reg   <= '0;
      lock_mode_reg <= MODE_MANUAL;
    end else if (accept && (state_reg == ST_IDLE)) begin
      lock_ch_reg   <= cur;
      lock_mode_reg <= mode;
    end
  end

  // Round-robin pointer moves only when a round-robin burst completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (wrap && (eff_mode == MODE_RR)) begin
      rr_ptr_reg <= (rr_ptr_reg == SEL_W'(N_CH - 1)) ? '0 : rr_ptr_reg + 1'b1;
    end
  end

  // Output register: load on accept, otherwise drain on output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_data_reg  <= ch_data[cur];
      out_ch_reg    <= cur;
      out_valid_reg <= 1'b1;
      out_last_reg  <= last;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == ST_BURST);

endmodule

// File: tb/tb_stream_mux_nch.sv
// Directed bench for stream_mux_nch: a 3-channel, 64-sample-burst instance
// plus a single-sample-burst instance, each scenario in its own task.
module tb_stream_mux_nch;

  localparam int DW = 8;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [23:0]   in_data;
  logic [2:0]    in_valid;
  logic [2:0]    in_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_ch;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  logic          b_mode;
  logic [1:0]    b_sel;
  logic [23:0]   b_in_data;
  logic [2:0]    b_in_valid;
  logic [2:0]    b_in_ready;
  logic [7:0]    b_out_data;
  logic [1:0]    b_out_ch;
  logic          b_out_valid;
  logic          b_out_ready;
  logic          b_out_last;
  logic          b_busy;

  int            n_checks = 0;
  int            n_fail   = 0;

  logic          auto_src;
  logic [23:0]   man_data;
  logic [5:0]    seq [3];

  always #5 clk = ~clk;

  // Per-channel sources: sample value is {channel, running index}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) seq[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (in_valid[k] && in_ready[k]) seq[k] <= seq[k] + 6'd1;
    end
  end

  assign in_data = auto_src ? {2'd2, seq[2], 2'd1, seq[1], 2'd0, seq[0]} : man_data;

  stream_mux_nch #(.DATA_W(DW), .N_CH(NC), .BURST_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  stream_mux_nch #(.DATA_W(DW), .N_CH(NC), .BURST_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    mode = 1'b0; sel = 2'd0; in_valid = 3'b000; out_ready = 1'b0;
    auto_src = 1'b1; man_data = '0;
    b_mode = 1'b0; b_sel = 2'd0; b_in_data = '0; b_in_valid = 3'b000; b_out_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    in_valid = 3'b111;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 000", in_ready); end
    in_valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 001", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_rr_order;
    int got, cyc, first_cyc, last_cyc;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    logic exp_last;
    do_reset();
    mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    got = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    while (got < 193 && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        exp_ch   = 2'((got / 64) % 3);
        exp_data = {exp_ch, 6'(got % 64)};
        exp_last = ((got % 64) == 63);
        n_checks++; if (out_ch !== exp_ch) begin n_fail++; $display("FAIL rr_ch sample %0d: got %0d expected %0d", got, out_ch, exp_ch); end
        n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL rr_data sample %0d: got %h expected %h", got, out_data, exp_data); end
        n_checks++; if (out_last !== exp_last) begin n_fail++; $display("FAIL rr_last sample %0d: got %b expected %b", got, out_last, exp_last); end
        if (got == 100) begin
          n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got %b expected 1", busy); end
        end
        if (got == 0)   first_cyc = cyc;
        if (got == 191) last_cyc  = cyc;
        got++;
      end
    end
    n_checks++; if (got != 193) begin n_fail++; $display("FAIL rr_timeout: got %0d samples expected 193", got); end
    n_checks++; if (last_cyc - first_cyc != 191) begin n_fail++; $display("FAIL rr_throughput: got %0d cycles expected 191", last_cyc - first_cyc); end
    $display("test_rr_order done: %0d samples", got);
  endtask

  task automatic test_manual_sel;
    int got, cyc;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    logic exp_last;
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 3'b111; out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 66 && cyc < 500) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        exp_ch   = (got < 64) ? 2'd2 : 2'd0;
        exp_data = {exp_ch, 6'(got % 64)};
        exp_last = (got == 63);
        n_checks++; if (out_ch !== exp_ch) begin n_fail++; $display("FAIL man_ch sample %0d: got %0d expected %0d", got, out_ch, exp_ch); end
        n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL man_data sample %0d: got %h expected %h", got, out_data, exp_data); end
        n_checks++; if (out_last !== exp_last) begin n_fail++; $display("FAIL man_last sample %0d: got %b expected %b", got, out_last, exp_last); end
        if (got == 9) sel = 2'd0;
        got++;
      end
    end
    n_checks++; if (got != 66) begin n_fail++; $display("FAIL man_timeout: got %0d samples expected 66", got); end
    $display("test_manual_sel done: %0d samples", got);
  endtask

  task automatic test_sel_invalid;
    do_reset();
    mode = 1'b0; sel = 2'd3; in_valid = 3'b111; out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL sel3_in_ready: got %b expected 000", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sel3_out_valid: got %b expected 0", out_valid); end
    end
    $display("test_sel_invalid done");
  endtask

  task automatic test_backpressure;
    int cyc;
    do_reset();
    auto_src = 1'b0; man_data = {8'hA5, 8'h11, 8'h22};
    mode = 1'b0; sel = 2'd2; in_valid = 3'b100; out_ready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!out_valid && cyc < 10);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_load: got out_valid %b expected 1", out_valid); end
    man_data[23:16] = 8'h3C;
    repeat (5) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_data: got %h expected a5", out_data); end
      n_checks++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL bp_ch: got %0d expected 2", out_ch); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL bp_last: got %b expected 0", out_last); end
      n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 000", in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 3'b100) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 100", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_reload_data: got %h expected 3c", out_data); end
    $display("test_backpressure done");
  endtask

  task automatic test_rr_stall;
    int got, cyc;
    logic [7:0] exp_data;
    do_reset();
    mode = 1'b1; in_valid = 3'b101; out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 64 && cyc < 500) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL stall_ch0 sample %0d: got %0d expected 0", got, out_ch); end
        got++;
      end
    end
    n_checks++; if (got != 64) begin n_fail++; $display("FAIL stall_ch0_timeout: got %0d expected 64", got); end
    repeat (10) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b expected 0", busy); end
      n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 010", in_ready); end
    end
    in_valid = 3'b111;
    got = 0; cyc = 0;
    while (got < 64 && cyc < 500) begin
      @(negedge clk); cyc++;
      if (out_valid) begin
        exp_data = {2'd1, 6'(got)};
        n_checks++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL stall_ch1 sample %0d: got %0d expected 1", got, out_ch); end
        n_checks++; if (out_data !== exp_data) begin n_fail++; $display("FAIL stall_data sample %0d: got %h expected %h", got, out_data, exp_data); end
        n_checks++; if (out_last !== (got == 63)) begin n_fail++; $display("FAIL stall_last sample %0d: got %b expected %b", got, out_last, got == 63); end
        got++;
      end
    end
    n_checks++; if (got != 64) begin n_fail++; $display("FAIL stall_ch1_timeout: got %0d expected 64", got); end
    $display("test_rr_stall done");
  endtask

  task automatic test_reset_midstream;
    int got, cyc;
    do_reset();
    mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 81 && cyc < 500) begin
      @(negedge clk); cyc++;
      if (out_valid) got++;
    end
    n_checks++; if (got != 81) begin n_fail++; $display("FAIL mid_timeout: got %0d expected 81", got); end
    n_checks++; if (busy !== 1'b1 || out_ch !== 2'd1) begin n_fail++; $display("FAIL mid_precondition: got busy %b ch %0d expected busy 1 ch 1", busy, out_ch); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!out_valid && cyc < 10);
    n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_first_after_reset: got valid %b ch %0d expected valid 1 ch 0", out_valid, out_ch); end
    $display("test_reset_midstream done");
  endtask

  task automatic test_burst1;
    int got, cyc;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    do_reset();
    b_mode = 1'b1; b_in_data = {8'hC2, 8'hB1, 8'hA0}; b_in_valid = 3'b111; b_out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 7 && cyc < 50) begin
      @(negedge clk); cyc++;
      n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL b1_busy cycle %0d: got %b expected 0", cyc, b_busy); end
      if (b_out_valid) begin
        exp_ch = 2'(got % 3);
        case (exp_ch)
          2'd0:    exp_data = 8'hA0;
          2'd1:    exp_data = 8'hB1;
          default: exp_data = 8'hC2;
        endcase
        n_checks++; if (b_out_ch !== exp_ch) begin n_fail++; $display("FAIL b1_ch sample %0d: got %0d expected %0d", got, b_out_ch, exp_ch); end
        n_checks++; if (b_out_data !== exp_data) begin n_fail++; $display("FAIL b1_data sample %0d: got %h expected %h", got, b_out_data, exp_data); end
        n_checks++; if (b_out_last !== 1'b1) begin n_fail++; $display("FAIL b1_last sample %0d: got %b expected 1", got, b_out_last); end
        got++;
      end
    end
    n_checks++; if (got != 7) begin n_fail++; $display("FAIL b1_timeout: got %0d expected 7", got); end
    $display("test_burst1 done");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_order();
    test_manual_sel();
    test_sel_invalid();
    test_backpressure();
    test_rr_stall();
    test_reset_midstream();
    test_burst1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
